// File: rtl/pokey_serout_tx_if.sv
// pokey_serout_tx_if: bus bundle for the POKEY serial output transmitter.
//   master : drives enn, wrEn, D, bitTick, txEn, brk; observes SO, busy, rdyPls, txDone
//   slave  : the transmitter side (inverse directions)
interface pokey_serout_tx_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic              enn;
   logic              wrEn;
   logic [DATA_W-1:0] D;
   logic              bitTick;
   logic              txEn;
   logic              brk;
   logic              SO;
   logic              busy;
   logic              rdyPls;
   logic              txDone;

   modport master (
      output enn, wrEn, D, bitTick, txEn, brk,
      input  SO, busy, rdyPls, txDone
   );

   modport slave (
      input  enn, wrEn, D, bitTick, txEn, brk,
      output SO, busy, rdyPls, txDone
   );
endinterface

// File: rtl/pokey_serout_tx.sv
// pokey_serout_tx: POKEY serial output transmitter.
// Double-buffered: holding register (SEROUT) feeds a shift register that sends
// start bit, DATA_W data bits LSB first, then STOP_BITS stop bits, one bit per
// accepted bitTick. All state moves on the falling clock edge when enn=1.
//   clk  : system clock (falling-edge active)
//   nR   : asynchronous active-low reset
//   bus  : slave modport -- enn, wrEn, D, bitTick, txEn, brk in;
//          SO, busy, rdyPls, txDone out
module pokey_serout_tx #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned STOP_BITS = 1
) (
   input logic              clk,
   input logic              nR,
   pokey_serout_tx_if.slave bus
);

   localparam int unsigned     CntW     = $clog2(DATA_W + 1);
   localparam logic [CntW-1:0] LastData = CntW'(DATA_W - 1);
   localparam logic [CntW-1:0] LastStop = CntW'(STOP_BITS - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hv_q, hv_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              rdy_q, rdy_d;
   logic              load;
   logic              so_bit;

   always_ff @(negedge clk or negedge nR) begin
      if (!nR) begin
         state_q <= StIdle;
         hold_q  <= '0;
         hv_q    <= 1'b0;
         shift_q <= '0;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         hv_q    <= hv_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      hv_d    = hv_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      rdy_d   = rdy_q;
      load    = 1'b0;
      if (bus.enn) begin
         rdy_d = 1'b0;
         if (!bus.txEn) begin
            // Abort: drop the frame but keep any pending holding data.
            state_d = StIdle;
            cnt_d   = '0;
         end else if (bus.bitTick) begin
            unique case (state_q)
               StIdle: load = hv_q;
               StStart: begin
                  state_d = StData;
                  cnt_d   = '0;
               end
               StData: begin
                  shift_d = shift_q >> 1;
                  if (cnt_q == LastData) begin
                     state_d = StStop;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               StStop: begin
                  if (cnt_q == LastStop) begin
                     cnt_d = '0;
                     // Pending data chains straight into the next start bit.
                     if (hv_q) load = 1'b1;
                     else      state_d = StIdle;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            endcase
         end
         if (load) begin
            shift_d = hold_q;
            hv_d    = 1'b0;
            rdy_d   = 1'b1;
            state_d = StStart;
            cnt_d   = '0;
         end
         // Write is applied after the transfer so a same-cycle write lands in hold.
         if (bus.wrEn) begin
            hold_d = bus.D;
            hv_d   = 1'b1;
         end
      end
   end

   always_comb begin
      so_bit = 1'b1;
      unique case (state_q)
         StIdle:  so_bit = 1'b1;
         StStart: so_bit = 1'b0;
         StData:  so_bit = shift_q[0];
         StStop:  so_bit = 1'b1;
      endcase
   end

   assign bus.SO     = so_bit & ~bus.brk;
   assign bus.busy   = (state_q != StIdle);
   assign bus.rdyPls = rdy_q;
   assign bus.txDone = (state_q == StIdle) & ~hv_q;

endmodule

// File: tb/tb_pokey_serout_tx.sv
// Bench for pokey_serout_tx: two DUTs (1 and 2 stop bits) share stimulus and
// are checked every cycle against a frame-position model, plus literal checks.
module tb_pokey_serout_tx;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          nR;
   logic          enn, wrEn, bitTick, txEn, brk;
   logic [DW-1:0] D;
   int unsigned   errors = 0;
   int unsigned   checks = 0;
   bit            mon_en = 1'b0;

   always #5 clk = ~clk;

   pokey_serout_tx_if #(.DATA_W(DW)) bus0 ();
   pokey_serout_tx_if #(.DATA_W(DW)) bus1 ();

   assign bus0.enn = enn;  assign bus0.wrEn = wrEn;  assign bus0.D = D;
   assign bus0.bitTick = bitTick;  assign bus0.txEn = txEn;  assign bus0.brk = brk;
   assign bus1.enn = enn;  assign bus1.wrEn = wrEn;  assign bus1.D = D;
   assign bus1.bitTick = bitTick;  assign bus1.txEn = txEn;  assign bus1.brk = brk;

   pokey_serout_tx #(.DATA_W(DW), .STOP_BITS(1)) u_dut_s1 (.clk(clk), .nR(nR), .bus(bus0));
   pokey_serout_tx #(.DATA_W(DW), .STOP_BITS(2)) u_dut_s2 (.clk(clk), .nR(nR), .bus(bus1));

   logic so_v [2], busy_v [2], rdy_v [2], done_v [2];
   assign so_v[0] = bus0.SO;      assign so_v[1] = bus1.SO;
   assign busy_v[0] = bus0.busy;  assign busy_v[1] = bus1.busy;
   assign rdy_v[0] = bus0.rdyPls; assign rdy_v[1] = bus1.rdyPls;
   assign done_v[0] = bus0.txDone; assign done_v[1] = bus1.txDone;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: position within frame (-1 idle, 0 start, 1..DW data, then stop bits).
   int            m_pos  [2];
   logic [DW-1:0] m_byte [2];
   logic [DW-1:0] m_hold [2];
   logic          m_hv   [2];
   logic          m_rdy  [2];
   logic          m_load;

   function automatic int stop_bits(int i);
      return (i == 0) ? 1 : 2;
   endfunction

   always @(negedge clk or negedge nR) begin
      if (!nR) begin
         for (int i = 0; i < 2; i++) begin
            m_pos[i] = -1; m_byte[i] = '0; m_hold[i] = '0; m_hv[i] = 1'b0; m_rdy[i] = 1'b0;
         end
      end else if (enn === 1'b1) begin
         for (int i = 0; i < 2; i++) begin
            m_load   = 1'b0;
            m_rdy[i] = 1'b0;
            if (txEn !== 1'b1) m_pos[i] = -1;
            else if (bitTick === 1'b1) begin
               if (m_pos[i] == -1)                  m_load = m_hv[i];
               else if (m_pos[i] < DW + stop_bits(i)) m_pos[i]++;
               else if (m_hv[i])                     m_load = 1'b1;
               else                                  m_pos[i] = -1;
            end
            if (m_load) begin
               m_byte[i] = m_hold[i]; m_hv[i] = 1'b0; m_pos[i] = 0; m_rdy[i] = 1'b1;
            end
            if (wrEn === 1'b1) begin
               m_hold[i] = D; m_hv[i] = 1'b1;
            end
         end
      end
   end

   function automatic logic exp_so(int i);
      logic b;
      if (m_pos[i] == -1)      b = 1'b1;
      else if (m_pos[i] == 0)  b = 1'b0;
      else if (m_pos[i] <= DW) b = m_byte[i][m_pos[i] - 1];
      else                     b = 1'b1;
      return b & ~brk;
   endfunction

   always @(posedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("so[%0d]", i), 32'(so_v[i]), 32'(exp_so(i)));
            chk($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_pos[i] != -1));
            chk($sformatf("rdyPls[%0d]", i), 32'(rdy_v[i]), 32'(m_rdy[i]));
            chk($sformatf("txDone[%0d]", i), 32'(done_v[i]), 32'(m_pos[i] == -1 && !m_hv[i]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [DW-1:0] d);
      wrEn = 1'b1; D = d; step(); wrEn = 1'b0;
   endtask

   task automatic do_tick();
      bitTick = 1'b1; step(); bitTick = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) do_tick();
   endtask

   task automatic collect(output logic [DW-1:0] b);
      for (int j = 0; j < DW; j++) begin
         do_tick();
         b[j] = bus0.SO;
      end
   endtask

   logic [10:0]   a5_so  = 11'b111_0100_1010;
   logic [20:0]   b2b_so = 21'b111111_00000_1_0000_1111_0;
   logic [DW-1:0] rx;

   initial begin
      enn = 1'b1; wrEn = 1'b0; bitTick = 1'b0; txEn = 1'b1; brk = 1'b0; D = '0; nR = 1'b0;
      step(); step();
      mon_en = 1'b1;
      chk("reset SO", 32'(bus0.SO), 32'd1);
      chk("reset busy", 32'(bus0.busy), 32'd0);
      chk("reset txDone", 32'(bus0.txDone), 32'd1);
      chk("reset rdyPls", 32'(bus0.rdyPls), 32'd0);
      nR = 1'b1; step();

      // Single frame 0xA5
      do_write(8'hA5);
      chk("a5 txDone pending", 32'(bus0.txDone), 32'd0);
      for (int k = 0; k < 11; k++) begin
         do_tick();
         chk($sformatf("a5 SO tick %0d", k), 32'(bus0.SO), 32'(a5_so[k]));
         if (k == 0) chk("a5 rdyPls", 32'(bus0.rdyPls), 32'd1);
         step();
      end
      chk("a5 busy end", 32'(bus0.busy), 32'd0);
      chk("a5 txDone end", 32'(bus0.txDone), 32'd1);
      chk("a5 2stop busy", 32'(bus1.busy), 32'd1);
      do_tick();
      chk("a5 2stop busy end", 32'(bus1.busy), 32'd0);

      // Back-to-back 0x0F then 0xF0
      do_write(8'h0F);
      do_tick();
      chk("b2b SO tick 0", 32'(bus0.SO), 32'(b2b_so[0]));
      do_write(8'hF0);
      for (int k = 1; k < 21; k++) begin
         do_tick();
         chk($sformatf("b2b SO tick %0d", k), 32'(bus0.SO), 32'(b2b_so[k]));
         if (k == 10) chk("b2b second rdyPls", 32'(bus0.rdyPls), 32'd1);
      end
      drain(3);

      // Overwrite, then write on the transfer cycle
      do_write(8'h11);
      do_write(8'h22);
      wrEn = 1'b1; D = 8'h33; bitTick = 1'b1; step(); wrEn = 1'b0; bitTick = 1'b0;
      chk("ovr rdyPls", 32'(bus0.rdyPls), 32'd1);
      chk("ovr txDone", 32'(bus0.txDone), 32'd0);
      collect(rx);
      chk("ovr first byte", 32'(rx), 32'h22);
      do_tick();
      chk("ovr stop", 32'(bus0.SO), 32'd1);
      do_tick();
      chk("ovr chained start", 32'(bus0.SO), 32'd0);
      chk("ovr chained rdyPls", 32'(bus0.rdyPls), 32'd1);
      collect(rx);
      chk("ovr second byte", 32'(rx), 32'h33);
      drain(4);
      chk("ovr idle", 32'(bus0.txDone), 32'd1);

      // Abort in data bit 3 with data pending
      do_write(8'h5A);
      drain(5);
      chk("abort bit3", 32'(bus0.SO), 32'd1);
      do_write(8'h77);
      txEn = 1'b0; step(); txEn = 1'b1;
      chk("abort SO", 32'(bus0.SO), 32'd1);
      chk("abort busy", 32'(bus0.busy), 32'd0);
      chk("abort hold kept", 32'(bus0.txDone), 32'd0);
      do_tick();
      chk("abort restart rdyPls", 32'(bus0.rdyPls), 32'd1);
      collect(rx);
      chk("abort pending byte", 32'(rx), 32'h77);
      drain(4);

      // enn freeze spanning a tick
      do_write(8'hC3);
      drain(2);
      enn = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bitTick = (k == 2); step();
      end
      bitTick = 1'b0; enn = 1'b1;
      chk("freeze busy", 32'(bus0.busy), 32'd1);
      chk("freeze SO bit0", 32'(bus0.SO), 32'd1);
      drain(2);
      chk("freeze SO bit2", 32'(bus0.SO), 32'd0);
      drain(10);

      // Break mid-frame: timing unaffected
      do_write(8'h96);
      drain(2);
      brk = 1'b1; step();
      chk("brk SO", 32'(bus0.SO), 32'd0);
      chk("brk busy", 32'(bus0.busy), 32'd1);
      drain(9);
      chk("brk busy end", 32'(bus0.busy), 32'd0);
      chk("brk 2stop busy", 32'(bus1.busy), 32'd1);
      brk = 1'b0; step();
      chk("brk released SO", 32'(bus0.SO), 32'd1);
      drain(2);

      // Reset mid-frame, then quiet line
      do_write(8'h00);
      drain(3);
      nR = 1'b0; #1;
      chk("async rst SO", 32'(bus0.SO), 32'd1);
      chk("async rst busy", 32'(bus0.busy), 32'd0);
      chk("async rst txDone", 32'(bus0.txDone), 32'd1);
      chk("async rst rdyPls", 32'(bus0.rdyPls), 32'd0);
      step(); nR = 1'b1; step();
      for (int k = 0; k < 20; k++) begin
         do_tick();
         chk("post-rst SO", 32'(bus0.SO), 32'd1);
      end

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         enn     = ($urandom_range(0, 9) != 0);
         wrEn    = ($urandom_range(0, 9) == 0);
         bitTick = ($urandom_range(0, 2) == 0);
         txEn    = ($urandom_range(0, 39) != 0);
         brk     = ($urandom_range(0, 19) == 0);
         D       = DW'($urandom);
         if ($urandom_range(0, 399) == 0) nR = 1'b0;
         step();
         nR = 1'b1;
      end
      enn = 1'b1; wrEn = 1'b0; bitTick = 1'b0; txEn = 1'b1; brk = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
